reg_pipe: RTL and testbench

REG_PIPE -- requirements
Module: reg_pipe

---
 rtl/reg_pipe.sv | 156 +++++++++++++++
 tb/tb_reg_pipe.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_pipe.sv
// ---------------------------------------------------------------------------
// reg_pipe -- elastic register pipeline with valid/ready handshake
//
// A chain of DEPTH register stages between an upstream valid/ready port and a
// downstream valid/ready port. Every stage holds one valid bit and one
// WIDTH-bit data word. When the output stalls, the stages compact, so bubbles
// move toward the output and fill. The input side stops accepting data only
// when all DEPTH stages are full. With no stall, a word reaches the output
// DEPTH cycles after it is accepted, and the pipeline moves one word per cycle.
//
// Parameters
//   WIDTH    data width in bits (>= 1)
//   DEPTH    number of register stages (>= 1)
//   RST_VAL  value loaded into every data register on reset or clear
//
// Ports
//   clk         in   sole clock, rising edge
//   reset_n     in   asynchronous active-low reset (deassertion sampled on clk)
//   sync_clr_i  in   synchronous clear; present only with REG_PIPE_SYNC_CLR_EN
//   valid_i     in   upstream word valid
//   ready_o     out  this block accepts a word this cycle
//   data_i      in   upstream word
//   valid_o     out  last stage holds a valid word
//   ready_i     in   downstream accepts a word this cycle
//   data_o      out  last-stage word, driven straight from a register
//   count_o     out  number of stages holding valid data (0..DEPTH)
//
// Configuration macro
//   REG_PIPE_SYNC_CLR_EN  when defined, adds sync_clr_i. A high sync_clr_i
//                         empties every stage and reloads RST_VAL. The clear
//                         takes priority over any transfer in the same cycle.
//                         When the macro is undefined, neither the port nor
//                         the clear logic exists.
// ---------------------------------------------------------------------------
module reg_pipe #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int              CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
`ifdef REG_PIPE_SYNC_CLR_EN
  input  logic             sync_clr_i,
`endif
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] count_o
);

  // Stage state: index 0 is the input side, DEPTH-1 drives the outputs.
  logic [DEPTH-1:0]            valid_q;
  logic [DEPTH-1:0]            valid_d;
  logic [DEPTH-1:0][WIDTH-1:0] data_q;
  logic [DEPTH-1:0][WIDTH-1:0] data_d;

  // load[k]: stage k may take a new value at the next edge.
  logic [DEPTH-1:0]            load;
  logic [CNT_W-1:0]            count_d;

  // -------------------------------------------------------------------------
  // Load conditions
  // A stage can load if it is empty or if its current word moves on this cycle.
  // The last stage moves on when ready_i is high. Stage k moves on when stage
  // k+1 can load. So stage k can load if ready_i is high or any stage from k
  // to the output is empty. A running OR from the output side computes this
  // in one pass. A bubble anywhere downstream lets every stage above it
  // advance, which collapses the bubbles during a stall.
  // -------------------------------------------------------------------------
  always_comb begin
    logic chain;
    load  = '0;
    chain = ready_i;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      chain   = chain || !valid_q[k];
      load[k] = chain;
    end
  end

  assign ready_o = load[0];

  // -------------------------------------------------------------------------
  // Next-state
  // A loading stage takes the valid bit of the stage before it, or valid_i at
  // stage 0. Its data register is written only when that incoming bit is set.
  // A stage that empties keeps its old data, so the data registers do not
  // toggle on bubbles.
  // -------------------------------------------------------------------------
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;

    if (load[0]) begin
      valid_d[0] = valid_i;
      if (valid_i) begin
        data_d[0] = data_i;
      end
    end

    for (int k = 1; k < DEPTH; k++) begin
      if (load[k]) begin
        valid_d[k] = valid_q[k-1];
        if (valid_q[k-1]) begin
          data_d[k] = data_q[k-1];
        end
      end
    end

`ifdef REG_PIPE_SYNC_CLR_EN
    // The clear overrides every transfer. A word offered in the same cycle is
    // dropped, although ready_o still reports the normal load condition.
    if (sync_clr_i) begin
      valid_d = '0;
      data_d  = {DEPTH{RST_VAL}};
    end
`endif
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      data_q  <= {DEPTH{RST_VAL}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  // -------------------------------------------------------------------------
  // Occupancy: popcount of the registered valid bits. It goes to zero as soon
  // as reset_n falls, because valid_q clears at that moment.
  // -------------------------------------------------------------------------
  always_comb begin
    count_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      count_d = count_d + CNT_W'(valid_q[k]);
    end
  end

  assign count_o = count_d;

  // -------------------------------------------------------------------------
  // Outputs come straight from the last stage, so nothing from data_i reaches
  // data_o without passing through a register.
  // -------------------------------------------------------------------------
  assign valid_o = valid_q[DEPTH-1];
  assign data_o  = data_q[DEPTH-1];

endmodule

// File: tb/tb_reg_pipe.sv
// ---------------------------------------------------------------------------
// tb_reg_pipe -- directed self-checking bench for reg_pipe
// (WIDTH=8, DEPTH=3, RST_VAL=8'hA5)
// ---------------------------------------------------------------------------
module tb_reg_pipe;

  localparam int               WIDTH   = 8;
  localparam int               DEPTH   = 3;
  localparam logic [WIDTH-1:0] RST_VAL = 8'hA5;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             sync_clr_i;
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] data_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] data_o;
  logic [1:0]       count_o;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  reg_pipe #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .RST_VAL(RST_VAL)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
`ifdef REG_PIPE_SYNC_CLR_EN
    .sync_clr_i(sync_clr_i),
`endif
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .data_i    (data_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .data_o    (data_o),
    .count_o   (count_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Step to 1 time unit past the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic outs(input string tag, input logic v, input logic [7:0] d, input logic [1:0] c);
    check({tag, ".valid_o"}, 32'(valid_o), 32'(v));
    check({tag, ".data_o"},  32'(data_o),  32'(d));
    check({tag, ".count_o"}, 32'(count_o), 32'(c));
  endtask

  initial begin
    reset_n    = 1'b1;
    sync_clr_i = 1'b0;
    valid_i    = 1'b0;
    ready_i    = 1'b0;
    data_i     = '0;

    // ---- Asynchronous reset between clock edges
    #1 reset_n = 1'b0;
    #1;
    outs("rst_async", 1'b0, 8'hA5, 2'd0);
    check("rst_async.ready_o", 32'(ready_o), 32'd1);
    step();
    step();
    reset_n = 1'b1;

    // ---- Unstalled stream 01..04
    ready_i = 1'b1;
    valid_i = 1'b1; data_i = 8'h01;
    step();
    outs("str_c1", 1'b0, 8'hA5, 2'd1);
    data_i = 8'h02;
    step();
    outs("str_c2", 1'b0, 8'hA5, 2'd2);
    data_i = 8'h03;
    step();
    outs("str_c3", 1'b1, 8'h01, 2'd3);
    data_i = 8'h04;
    step();
    outs("str_c4", 1'b1, 8'h02, 2'd3);
    valid_i = 1'b0;
    step();
    outs("str_c5", 1'b1, 8'h03, 2'd2);
    step();
    outs("str_c6", 1'b1, 8'h04, 2'd1);
    step();
    outs("str_c7", 1'b0, 8'h04, 2'd0);

    // ---- Stall: push 10..14 with ready_i low
    ready_i = 1'b0;
    valid_i = 1'b1; data_i = 8'h10;
    step();
    data_i = 8'h11;
    step();
    data_i = 8'h12;
    step();
    outs("stall_full", 1'b1, 8'h10, 2'd3);
    check("stall_full.ready_o", 32'(ready_o), 32'd0);
    data_i = 8'h13;
    step();
    outs("stall_hold", 1'b1, 8'h10, 2'd3);
    check("stall_hold.ready_o", 32'(ready_o), 32'd0);
    ready_i = 1'b1;
    #1;
    check("stall_release.ready_o", 32'(ready_o), 32'd1);
    step();
    outs("drain_1", 1'b1, 8'h11, 2'd3);
    data_i = 8'h14;
    step();
    outs("drain_2", 1'b1, 8'h12, 2'd3);
    valid_i = 1'b0;
    step();
    outs("drain_3", 1'b1, 8'h13, 2'd2);
    step();
    outs("drain_4", 1'b1, 8'h14, 2'd1);
    step();
    outs("drain_5", 1'b0, 8'h14, 2'd0);

    // ---- Full with simultaneous in/out
    ready_i = 1'b0;
    valid_i = 1'b1; data_i = 8'h30;
    step();
    data_i = 8'h31;
    step();
    data_i = 8'h32;
    step();
    outs("pass_full", 1'b1, 8'h30, 2'd3);
    ready_i = 1'b1; data_i = 8'h20;
    step();
    outs("pass_swap", 1'b1, 8'h31, 2'd3);
    valid_i = 1'b0;
    step();
    outs("pass_2", 1'b1, 8'h32, 2'd2);
    step();
    outs("pass_3", 1'b1, 8'h20, 2'd1);
    step();
    outs("pass_4", 1'b0, 8'h20, 2'd0);

    // ---- Reset pulse with two words in flight
    valid_i = 1'b1; data_i = 8'h40;
    step();
    data_i = 8'h41;
    step();
    valid_i = 1'b0;
    step();
    outs("mid_before", 1'b1, 8'h40, 2'd2);
    #2 reset_n = 1'b0;
    #1;
    outs("mid_rst", 1'b0, 8'hA5, 2'd0);
    check("mid_rst.ready_o", 32'(ready_o), 32'd1);
    #1 reset_n = 1'b1;
    step();
    outs("mid_after1", 1'b0, 8'hA5, 2'd0);
    step();
    outs("mid_after2", 1'b0, 8'hA5, 2'd0);
    step();
    outs("mid_after3", 1'b0, 8'hA5, 2'd0);

`ifdef REG_PIPE_SYNC_CLR_EN
    // ---- Synchronous clear beats a concurrent push
    ready_i = 1'b0;
    valid_i = 1'b1; data_i = 8'h60;
    step();
    data_i = 8'h61;
    step();
    data_i = 8'h62;
    step();
    outs("clr_full", 1'b1, 8'h60, 2'd3);
    sync_clr_i = 1'b1; data_i = 8'h55;
    #1;
    check("clr_req.ready_o", 32'(ready_o), 32'd0);
    step();
    outs("clr_done", 1'b0, 8'hA5, 2'd0);
    sync_clr_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    step();
    outs("clr_after1", 1'b0, 8'hA5, 2'd0);
    step();
    outs("clr_after2", 1'b0, 8'hA5, 2'd0);
    step();
    outs("clr_after3", 1'b0, 8'hA5, 2'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
